spike_event_packetizer: RTL and testbench

- Downstream consumer of processing_system.
- Captures per-unit spike flags and 2-bit event codes, timestamps them, and arbitrates them round-robin into a packet FIFO.
- Serialises each packet as a self-synchronising 2-byte stream on an 8-bit valid/ready port, suitable for the chip's output pins or a UART/SPI framer.

---
 rtl/spike_event_packetizer_if.sv | 19 +
 rtl/spike_event_packetizer.sv | 240 ++++++++++++++++++++++++
 tb/tb_spike_event_packetizer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_event_packetizer_if.sv
// spike_event_packetizer_if: 8-bit valid/ready output byte stream.
// master drives data/valid, slave drives ready.
interface spike_event_packetizer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/spike_event_packetizer.sv
// spike_event_packetizer: timestamps unit spike events, arbitrates them into a
// packet FIFO and streams 2-byte packets. Optional: SPIKE_PKT_DROP_MARKER_EN.
module spike_event_packetizer #(
    parameter int NUM_UNITS   = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_PRESCALE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        spike_detection_array,
    input  logic [2*NUM_UNITS-1:0]      event_out_array,
    spike_event_packetizer_if.master    stream,
    output logic                        overflow,
    input  logic                        clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int PSW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

    logic [8:0]                ts_q, ts_d;
    logic [PSW-1:0]            pre_q, pre_d;
    logic [NUM_UNITS-1:0]      pend_q, pend_d;
    logic [NUM_UNITS-1:0][1:0] cls_q, cls_d;
    logic [NUM_UNITS-1:0][8:0] tsn_q, tsn_d;
    logic [2:0]                rr_q, rr_d;
    logic                      ov_q, ov_d;
    logic [3:0]                drops;

    logic                      hi_vld, lo_vld, gnt_vld;
    logic [2:0]                hi_id, lo_id, gnt_id;
    logic [NUM_UNITS-1:0]      gnt_oh;
    logic [13:0]               push_data;
    logic                      push, can_push;

    logic [13:0]               mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]             lvl_q, lvl_d;
    logic                      full, empty;
    logic [13:0]               head;

    state_t                    state_q, state_d;
    logic [7:0]                dat_q, dat_d, b1_q, b1_d;
    logic                      vld_q, vld_d;
    logic                      hs, load, pop;

`ifdef SPIKE_PKT_DROP_MARKER_EN
    logic [6:0]                dc_q, dc_d, dc_base;
    logic [7:0]                dc_sum;
    logic                      mk_load;
`endif

    assign hs       = vld_q & stream.out_ready;
    assign full     = (lvl_q == LW'(FIFO_DEPTH));
    assign empty    = (lvl_q == '0);
    assign head     = mem_q[rd_q];
    assign can_push = !full | pop;
    assign push     = gnt_vld;

    assign stream.out_data  = dat_q;
    assign stream.out_valid = vld_q;
    assign overflow         = ov_q;
    assign fifo_level       = lvl_q;

    // Free-running timestamp advanced once per prescaler period.
    always_comb begin
        pre_d = pre_q + PSW'(1);
        ts_d  = ts_q;
        if (pre_q == PSW'(TS_PRESCALE - 1)) begin
            pre_d = '0;
            ts_d  = ts_q + 9'd1;
        end
    end

    // Serializer FSM: loads marker or FIFO head into byte0, then byte1.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        b1_d    = b1_q;
        pop     = 1'b0;
        load    = 1'b0;
`ifdef SPIKE_PKT_DROP_MARKER_EN
        mk_load = 1'b0;
`endif
        unique case (state_q)
            IDLE:  load = 1'b1;
            BYTE0: begin
                if (hs) begin
                    state_d = BYTE1;
                    dat_d   = b1_q;
                end
            end
            BYTE1: load = hs;
            default: state_d = IDLE;
        endcase
        if (load) begin
`ifdef SPIKE_PKT_DROP_MARKER_EN
            if (dc_q != '0) begin
                mk_load = 1'b1;
                state_d = BYTE0;
                vld_d   = 1'b1;
                dat_d   = 8'hFF;
                b1_d    = {1'b0, dc_q};
            end else
`endif
            if (!empty) begin
                pop     = 1'b1;
                state_d = BYTE0;
                vld_d   = 1'b1;
                dat_d   = {1'b1, head[13:7]};
                b1_d    = {1'b0, head[6:0]};
            end else begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        end
    end

    // Round-robin grant: lowest pending id at/after rr_q, else lowest overall.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (pend_q[u]) begin
                lo_vld = 1'b1;
                lo_id  = 3'(u);
                if (u >= int'(rr_q)) begin
                    hi_vld = 1'b1;
                    hi_id  = 3'(u);
                end
            end
        end
        gnt_vld   = (hi_vld | lo_vld) & can_push;
        gnt_id    = hi_vld ? hi_id : lo_id;
        gnt_oh    = '0;
        push_data = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (gnt_vld && gnt_id == 3'(u)) begin
                gnt_oh[u] = 1'b1;
                push_data = {cls_q[u], 3'(u), tsn_q[u]};
            end
        end
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_id == 3'(NUM_UNITS - 1)) ? 3'd0 : gnt_id + 3'd1;
        end
    end

    // Capture: latch new events, count those hitting a busy latch.
    always_comb begin
        pend_d = pend_q;
        cls_d  = cls_q;
        tsn_d  = tsn_q;
        drops  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end
            if (spike_detection_array[i]) begin
                if (!pend_q[i] || gnt_oh[i]) begin
                    pend_d[i] = 1'b1;
                    cls_d[i]  = event_out_array[2*i +: 2];
                    tsn_d[i]  = ts_q;
                end else begin
                    drops = drops + 4'd1;
                end
            end
        end
        ov_d = (drops != '0) ? 1'b1 : (clear_overflow ? 1'b0 : ov_q);
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        lvl_d = lvl_q + LW'(push) - LW'(pop);
    end

`ifdef SPIKE_PKT_DROP_MARKER_EN
    // Drop counter: restarts on clear or marker load; new drops always count.
    always_comb begin
        dc_base = (clear_overflow || mk_load) ? '0 : dc_q;
        dc_sum  = {1'b0, dc_base} + {4'b0, drops};
        dc_d    = dc_sum[7] ? 7'h7F : dc_sum[6:0];
    end
`endif

    // FIFO storage; contents need no reset since pointers do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q    <= '0;
            pre_q   <= '0;
            pend_q  <= '0;
            cls_q   <= '0;
            tsn_q   <= '0;
            rr_q    <= '0;
            ov_q    <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            state_q <= IDLE;
            dat_q   <= '0;
            b1_q    <= '0;
            vld_q   <= 1'b0;
`ifdef SPIKE_PKT_DROP_MARKER_EN
            dc_q    <= '0;
`endif
        end else begin
            ts_q    <= ts_d;
            pre_q   <= pre_d;
            pend_q  <= pend_d;
            cls_q   <= cls_d;
            tsn_q   <= tsn_d;
            rr_q    <= rr_d;
            ov_q    <= ov_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lvl_q   <= lvl_d;
            state_q <= state_d;
            dat_q   <= dat_d;
            b1_q    <= b1_d;
            vld_q   <= vld_d;
`ifdef SPIKE_PKT_DROP_MARKER_EN
            dc_q    <= dc_d;
`endif
        end
    end
endmodule

// File: tb/tb_spike_event_packetizer.sv
// tb_spike_event_packetizer: directed and random stimulus against a
// queue-based packet model of the spike event packetizer.
module tb_spike_event_packetizer;
    localparam int N = 4;
    localparam int D = 8;
    localparam int P = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] spike;
    logic [2*N-1:0] ev;
    logic         clr;
    logic         ov;
    logic [3:0]   lvl;

    spike_event_packetizer_if sif ();

    spike_event_packetizer #(
        .NUM_UNITS(N), .FIFO_DEPTH(D), .TS_PRESCALE(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spike_detection_array(spike),
        .event_out_array(ev),
        .stream(sif),
        .overflow(ov),
        .clear_overflow(clr),
        .fifo_level(lvl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] got[$];

    // reference model state
    bit          m_pend[N];
    logic [1:0]  m_cls[N];
    logic [8:0]  m_tsn[N];
    int          m_rr;
    logic [13:0] m_q[$];
    int          m_ph;
    logic [15:0] m_cur;
    logic [8:0]  m_ts;
    int          m_pre;
    bit          m_ov;
    int          m_dc;

    task automatic model_step();
        bit hs, want, mk;
        int g, drops, base, u;
        logic [13:0] e;
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_rr = 0; m_q.delete(); m_ph = 0; m_cur = '0;
            m_ts = '0; m_pre = 0; m_ov = 0; m_dc = 0;
            return;
        end
        hs = (m_ph != 0) && sif.out_ready;
        want = (m_ph == 0) || (m_ph == 2 && hs);
        mk = 0;
        if (m_ph == 1 && hs) m_ph = 2;
        else if (want) begin
            m_ph = 0;
`ifdef SPIKE_PKT_DROP_MARKER_EN
            if (m_dc > 0) begin
                m_cur = {8'hFF, 1'b0, 7'(m_dc)}; m_ph = 1; mk = 1;
            end else
`endif
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_cur = {1'b1, e[13:7], 1'b0, e[6:0]};
                m_ph = 1;
            end
        end
        g = -1;
        if (m_q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                u = (m_rr + k) % N;
                if (g < 0 && m_pend[u]) g = u;
            end
        end
        if (g >= 0) begin
            m_q.push_back({m_cls[g], 3'(g), m_tsn[g]});
            m_pend[g] = 0;
            m_rr = (g + 1) % N;
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            if (spike[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1; m_cls[i] = ev[2*i +: 2]; m_tsn[i] = m_ts;
                end else drops++;
            end
        end
        base = (clr || mk) ? 0 : m_dc;
        m_dc = (drops > 0) ? ((base + drops > 127) ? 127 : base + drops) : base;
        if (drops > 0) m_ov = 1;
        else if (clr) m_ov = 0;
        if (m_pre == P - 1) begin m_pre = 0; m_ts = m_ts + 9'd1; end
        else m_pre++;
    endtask

    function automatic logic [13:0] act_vec();
        return {sif.out_valid, sif.out_valid ? sif.out_data : 8'h00, lvl, ov};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [7:0] d;
        d = (m_ph == 1) ? m_cur[15:8] : (m_ph == 2) ? m_cur[7:0] : 8'h00;
        return {m_ph != 0, d, 4'(m_q.size()), m_ov};
    endfunction

    task automatic tick();
        if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) got.push_back(sif.out_data);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; spike = '0; ev = '0; clr = 0; sif.out_ready = 1;
        tick(); tick();
        rst = 0;
        got.delete();
    endtask

    task automatic wait_ts(input int t);
        for (int c = 0; c < 600 && m_ts != 9'(t); c++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (sif.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", sif.out_valid); end
        n_checks++;
        if (sif.out_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", sif.out_data); end
        n_checks++;
        if (lvl !== 4'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", lvl); end
        n_checks++;
        if (ov !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", ov); end
    endtask

    task automatic test_single_spike();
        do_reset();
        wait_ts(5);
        spike = 4'b0100; ev = 8'h10;
        tick();
        spike = '0; ev = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL single_cycle: got %h want %h", act_vec(), exp_vec()); end
        end
        n_checks++;
        if (got.size() != 2 || got[0] !== 8'hA8 || got[1] !== 8'h05) begin
            n_errors++; $display("FAIL single_bytes: got n=%0d %h %h want 2 a8 05", got.size(), got[0], got[1]);
        end
        n_checks++;
        if (sif.out_valid !== 1'b0 || lvl !== 4'd0) begin
            n_errors++; $display("FAIL single_idle: got v=%b lvl=%0d want v=0 lvl=0", sif.out_valid, lvl);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_b[8];
        exp_b = '{8'h80, 8'h40, 8'hA4, 8'h40, 8'hC8, 8'h40, 8'hEC, 8'h40};
        do_reset();
        wait_ts(64);
        spike = 4'hF; ev = 8'hE4;
        tick();
        spike = '0; ev = '0;
        for (int c = 0; c < 24; c++) begin
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL simul_cycle: got %h want %h", act_vec(), exp_vec()); end
        end
        n_checks++;
        if (got.size() != 8) begin n_errors++; $display("FAIL simul_count: got %0d want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_b[i]) begin n_errors++; $display("FAIL simul_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[4];
        exp_b = '{8'hA8, 8'h05, 8'hC0, 8'h06};
        do_reset();
        sif.out_ready = 0;
        wait_ts(5);
        spike = 4'b0100; ev = 8'h10;
        tick();
        spike = 4'b0001; ev = 8'h02;
        tick();
        spike = '0; ev = '0;
        for (int c = 0; c < 10 && sif.out_valid !== 1'b1; c++) tick();
        n_checks++;
        if (sif.out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_timeout: out_valid got %b want 1", sif.out_valid); end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (sif.out_valid !== 1'b1 || sif.out_data !== 8'hA8) begin
                n_errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=a8", sif.out_valid, sif.out_data);
            end
        end
        sif.out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL bp_cycle: got %h want %h", act_vec(), exp_vec()); end
        end
        n_checks++;
        if (got.size() != 4) begin n_errors++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_b[i]) begin n_errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        sif.out_ready = 0;
        spike = 4'b0010; ev = 8'h0C;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL ovf_fill: got %h want %h", act_vec(), exp_vec()); end
        end
        spike = '0; ev = '0;
        tick();
        n_checks++;
        if (lvl !== 4'(D)) begin n_errors++; $display("FAIL ovf_level: got %0d want %0d", lvl, D); end
        n_checks++;
        if (ov !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", ov); end
        sif.out_ready = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL ovf_drain: got %h want %h", act_vec(), exp_vec()); end
        end
`ifdef SPIKE_PKT_DROP_MARKER_EN
        n_checks++;
        if (got.size() != 22 || got[2] !== 8'hFF || got[3] !== 8'h0A) begin
            n_errors++; $display("FAIL ovf_marker: got n=%0d %h %h want 22 ff 0a", got.size(), got[2], got[3]);
        end
`else
        n_checks++;
        if (got.size() != 20) begin n_errors++; $display("FAIL ovf_count: got %0d want 20", got.size()); end
`endif
        n_checks++;
        if (lvl !== 4'd0 || ov !== 1'b1) begin
            n_errors++; $display("FAIL ovf_sticky: got lvl=%0d ov=%b want 0 1", lvl, ov);
        end
        clr = 1;
        tick();
        clr = 0;
        n_checks++;
        if (ov !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", ov); end
    endtask

    task automatic test_ts_wrap();
        logic [7:0] exp_b[4];
        exp_b = '{8'h83, 8'h7F, 8'h80, 8'h01};
        do_reset();
        wait_ts(511);
        spike = 4'b0001; ev = '0;
        tick();
        spike = '0;
        tick();
        spike = 4'b0001;
        tick();
        spike = '0;
        for (int c = 0; c < 14; c++) begin
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL wrap_cycle: got %h want %h", act_vec(), exp_vec()); end
        end
        n_checks++;
        if (got.size() != 4) begin n_errors++; $display("FAIL wrap_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_b[i]) begin n_errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [8:0] t;
        do_reset();
        spike = 4'hF; ev = 8'hE4;
        tick();
        spike = 4'b1000;
        tick();
        spike = '0; ev = '0;
        for (int c = 0; c < 10 && sif.out_valid !== 1'b1; c++) tick();
        n_checks++;
        if (sif.out_valid !== 1'b1 || ov !== 1'b1) begin
            n_errors++; $display("FAIL mid_setup: got v=%b ov=%b want 1 1", sif.out_valid, ov);
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if (sif.out_valid !== 1'b0 || lvl !== 4'd0 || ov !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: got v=%b lvl=%0d ov=%b want 0 0 0", sif.out_valid, lvl, ov);
        end
        got.delete();
        t = m_ts;
        spike = 4'b0010; ev = 8'h08;
        tick();
        spike = '0; ev = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL mid_cycle: got %h want %h", act_vec(), exp_vec()); end
        end
        n_checks++;
        if (got.size() != 2 || got[0] !== {3'b110, 3'b001, t[8:7]} || got[1] !== {1'b0, t[6:0]}) begin
            n_errors++;
            $display("FAIL mid_restart: got n=%0d %h %h want 2 %h %h", got.size(), got[0], got[1],
                     {3'b110, 3'b001, t[8:7]}, {1'b0, t[6:0]});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c < 400) spike = N'($urandom & $urandom & $urandom);
            else spike = N'($urandom & $urandom);
            ev = (2*N)'($urandom);
            sif.out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin n_errors++; $display("FAIL random_cycle%0d: got %h want %h", c, act_vec(), exp_vec()); end
        end
        spike = '0; clr = 0; sif.out_ready = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1; spike = '0; ev = '0; clr = 0; sif.out_ready = 1;
        test_reset();
        test_single_spike();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_ts_wrap();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
